// File: rtl/seg_scan_display_if.sv
// Bus bundle for seg_scan_display: capture controls in, status and
// multiplexed seven-segment drive out.
interface seg_scan_display_if #(
  parameter int DIGITS = 8,
  parameter int DATA_W = 32,
  parameter int NUM_CH = 2
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH*DATA_W-1:0] data_in;
  logic [SEL_W-1:0]         ch_sel;
  logic                     mode;
  logic                     blank_lz;
  logic                     update;
  logic                     busy;
  logic                     ovf;
  logic [6:0]               out7;
  logic [DIGITS-1:0]        en_out;

  modport master (
    output data_in, ch_sel, mode, blank_lz, update,
    input  busy, ovf, out7, en_out
  );

  modport slave (
    input  data_in, ch_sel, mode, blank_lz, update,
    output busy, ovf, out7, en_out
  );
endinterface

// File: rtl/seg_scan_display.sv
// Multiplexed common-anode seven-segment driver: captures one channel, renders it
// as hex or decimal (serial double-dabble), and scans the digits with blanking.
module seg_scan_display #(
  parameter int DIGITS   = 8,
  parameter int DATA_W   = 32,
  parameter int NUM_CH   = 2,
  parameter int SCAN_DIV = 100000
) (
  input logic Clk,
  input logic Rst,
  seg_scan_display_if.slave bus
);
  localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DISP_W     = 4 * DIGITS;
  localparam int BCD_DIGITS = (DATA_W * 30103 + 99999) / 100000 + 1;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int EXT_W      = (DATA_W > DISP_W) ? DATA_W : DISP_W;
  localparam int DEXT_W     = (BCD_W > DISP_W) ? BCD_W : DISP_W;
  localparam int CNT_W      = $clog2(DATA_W);
  localparam int IDX_W      = $clog2(DIGITS);
  localparam int DIV_W      = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE, HEX, DEC} state_t;

  state_t              state, stateNext;
  logic                busy, capture, shiftEn, writeHex, writeDec;
  logic [CNT_W-1:0]    bitCnt;
  logic [DATA_W-1:0]   chVal, valReg;
  logic [BCD_W-1:0]    bcdReg, bcdAdj, bcdNext;
  logic [EXT_W-1:0]    valExt;
  logic [DEXT_W-1:0]   decExt;
  logic [DISP_W-1:0]   dispReg, dispShift;
  logic                ovfReg;
  logic [DIV_W-1:0]    divCnt;
  logic [IDX_W-1:0]    idx;
  logic                blankDig;
  logic [6:0]          segOut_p1;
  logic [DIGITS-1:0]   digEn_p1;

  function automatic logic [6:0] segDecode(input logic [3:0] nib);
    case (nib)
      4'h0: segDecode = 7'b0000001;
      4'h1: segDecode = 7'b1001111;
      4'h2: segDecode = 7'b0010010;
      4'h3: segDecode = 7'b0000110;
      4'h4: segDecode = 7'b1001100;
      4'h5: segDecode = 7'b0100100;
      4'h6: segDecode = 7'b0100000;
      4'h7: segDecode = 7'b0001111;
      4'h8: segDecode = 7'b0000000;
      4'h9: segDecode = 7'b0000100;
      4'hA: segDecode = 7'b0001000;
      4'hB: segDecode = 7'b1100000;
      4'hC: segDecode = 7'b0110001;
      4'hD: segDecode = 7'b1000010;
      4'hE: segDecode = 7'b0110000;
      default: segDecode = 7'b0111000;
    endcase
  endfunction

  always_ff @(posedge Clk) begin
    if (!Rst) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (bus.update) stateNext = bus.mode ? DEC : HEX;
      HEX:     stateNext = IDLE;
      DEC:     if (bitCnt == CNT_W'(DATA_W - 1)) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    capture  = (state == IDLE) && bus.update;
    shiftEn  = (state == DEC);
    writeHex = (state == HEX);
    writeDec = (state == DEC) && (bitCnt == CNT_W'(DATA_W - 1));
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    chVal = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (bus.ch_sel == SEL_W'(k)) chVal = bus.data_in[k*DATA_W +: DATA_W];
  end

  always_comb begin
    bcdAdj = bcdReg;
    for (int i = 0; i < BCD_DIGITS; i++)
      if (bcdReg[4*i +: 4] >= 4'd5) bcdAdj[4*i +: 4] = bcdReg[4*i +: 4] + 4'd3;
    bcdNext = {bcdAdj[BCD_W-2:0], valReg[DATA_W-1]};
    valExt  = EXT_W'(valReg);
    decExt  = DEXT_W'(bcdNext);
  end

  always_ff @(posedge Clk) begin
    if (capture) begin
      valReg <= chVal;
      bcdReg <= '0;
    end else if (shiftEn) begin
      valReg <= {valReg[DATA_W-2:0], 1'b0};
      bcdReg <= bcdNext;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      bitCnt  <= '0;
      dispReg <= '0;
      ovfReg  <= 1'b0;
    end else begin
      if (capture)      bitCnt <= '0;
      else if (shiftEn) bitCnt <= bitCnt + 1'b1;
      if (writeHex) begin
        dispReg <= valExt[DISP_W-1:0];
        ovfReg  <= |(valExt >> DISP_W);
      end else if (writeDec) begin
        dispReg <= decExt[DISP_W-1:0];
        ovfReg  <= |(decExt >> DISP_W);
      end
    end
  end

  // A digit is blank when it and everything above it is zero; digit 0 always shows.
  always_comb begin
    dispShift = dispReg >> (4 * idx);
    blankDig  = bus.blank_lz && (idx != '0) && (dispShift == '0);
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      divCnt    <= '0;
      idx       <= '0;
      segOut_p1 <= 7'h7F;
      digEn_p1  <= '1;
    end else begin
      if (divCnt == DIV_W'(SCAN_DIV - 1)) begin
        divCnt <= '0;
        idx    <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        divCnt <= divCnt + 1'b1;
      end
      segOut_p1 <= blankDig ? 7'h7F : segDecode(dispShift[3:0]);
      digEn_p1  <= ~(DIGITS'(1) << idx);
    end
  end

  assign bus.busy   = busy;
  assign bus.ovf    = ovfReg;
  assign bus.out7   = segOut_p1;
  assign bus.en_out = digEn_p1;
endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display: expected display contents are queued at
// capture time and compared against the scanned segments after each conversion.
module tb_seg_scan_display;
  localparam int DIGITS = 8, DATA_W = 32, NUM_CH = 3, SCAN_DIV = 4;

  typedef struct {
    logic [31:0] disp;
    logic        ovf;
    int          blen;
  } exp_t;

  logic Clk = 1'b0;
  logic Rst;
  int   nChecks = 0;
  int   nErrors = 0;
  exp_t expQ[$];
  logic [6:0] segSeen [DIGITS];
  logic [6:0] segTab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  seg_scan_display_if #(.DIGITS(DIGITS), .DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus ();

  seg_scan_display #(.DIGITS(DIGITS), .DATA_W(DATA_W), .NUM_CH(NUM_CH),
                     .SCAN_DIV(SCAN_DIV)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic exp_t model(input logic [31:0] val, input logic m);
    exp_t e;
    longint unsigned v;
    e.blen = m ? DATA_W : 1;
    if (!m) begin
      e.disp = val;
      e.ovf  = 1'b0;
    end else begin
      v = longint'(val);
      for (int i = 0; i < DIGITS; i++) begin
        e.disp[4*i +: 4] = 4'(v % 10);
        v = v / 10;
      end
      e.ovf = (v != 0);
    end
    return e;
  endfunction

  task automatic setCh(input int ch, input logic [31:0] val);
    if (ch < NUM_CH) bus.data_in[ch*DATA_W +: DATA_W] = val;
  endtask

  task automatic startConv(input int ch, input logic [31:0] val, input logic m, input bit doPush);
    setCh(ch, val);
    bus.ch_sel = 2'(ch);
    bus.mode   = m;
    checkVal("busy_idle", 64'(bus.busy), 64'd0);
    bus.update = 1'b1;
    tick();
    bus.update = 1'b0;
    if (doPush) expQ.push_back(model((ch < NUM_CH) ? val : 32'd0, m));
  endtask

  task automatic verifyDisp(input exp_t e, input logic blz);
    int msd;
    logic [6:0] want;
    bus.blank_lz = blz;
    tick();
    for (int i = 0; i < DIGITS; i++) segSeen[i] = 'x;
    repeat (DIGITS * SCAN_DIV + 4) begin
      tick();
      for (int i = 0; i < DIGITS; i++)
        if (bus.en_out == ~(8'd1 << i)) segSeen[i] = bus.out7;
    end
    msd = 0;
    for (int i = 0; i < DIGITS; i++) if (e.disp[4*i +: 4] != 4'd0) msd = i;
    for (int i = 0; i < DIGITS; i++) begin
      want = (blz && i > msd) ? 7'h7F : segTab[e.disp[4*i +: 4]];
      checkVal($sformatf("digit%0d", i), 64'(segSeen[i]), 64'(want));
    end
  endtask

  task automatic waitDone(input logic blz, input int collideAt);
    int n;
    exp_t e;
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      if (n == collideAt) begin
        setCh(0, 32'd99);
        bus.update = 1'b1;
      end
      tick();
      bus.update = 1'b0;
    end
    if (expQ.size() == 0) begin
      checkVal("queue_empty", 64'd1, 64'd0);
      return;
    end
    e = expQ.pop_front();
    checkVal("busy_len", 64'(n), 64'(e.blen));
    tick();
    checkVal("busy_after", 64'(bus.busy), 64'd0);
    checkVal("ovf", 64'(bus.ovf), 64'(e.ovf));
    verifyDisp(e, blz);
  endtask

  initial begin
    exp_t e;
    Rst = 1'b0;
    bus.data_in  = '0;
    bus.ch_sel   = '0;
    bus.mode     = 1'b0;
    bus.blank_lz = 1'b0;
    bus.update   = 1'b0;
    repeat (3) tick();
    checkVal("rst_out7", 64'(bus.out7), 64'h7F);
    checkVal("rst_en", 64'(bus.en_out), 64'hFF);
    checkVal("rst_busy", 64'(bus.busy), 64'd0);
    checkVal("rst_ovf", 64'(bus.ovf), 64'd0);

    Rst = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      checkVal($sformatf("scan_en%0d", k), 64'(bus.en_out), 64'(8'(~(8'd1 << ((k / 4) % 8)))));
    end

    setCh(0, 32'hDEADBEEF);
    startConv(1, 32'h1234ABCD, 1'b0, 1'b1);
    waitDone(1'b0, 0);
    startConv(0, 32'd12345678, 1'b1, 1'b1);
    waitDone(1'b0, 0);
    startConv(0, 32'hFFFFFFFF, 1'b1, 1'b1);
    waitDone(1'b0, 0);
    startConv(1, 32'd5, 1'b1, 1'b1);
    waitDone(1'b0, 0);
    startConv(2, 32'd42, 1'b1, 1'b1);
    waitDone(1'b1, 0);
    startConv(0, 32'd0, 1'b1, 1'b1);
    waitDone(1'b1, 0);
    startConv(3, 32'h0, 1'b0, 1'b1);
    waitDone(1'b1, 0);
    startConv(0, 32'd12345678, 1'b1, 1'b1);
    waitDone(1'b0, 10);
    startConv(1, 32'd42, 1'b1, 1'b1);
    waitDone(1'b1, 32);
    startConv(0, 32'hFFFFFFFF, 1'b1, 1'b1);
    waitDone(1'b0, 0);

    // Abort a decimal conversion at its 20th busy cycle.
    startConv(0, 32'd87654321, 1'b1, 1'b0);
    repeat (19) tick();
    checkVal("abort_busy_pre", 64'(bus.busy), 64'd1);
    Rst = 1'b0;
    tick();
    checkVal("abort_busy", 64'(bus.busy), 64'd0);
    checkVal("abort_ovf", 64'(bus.ovf), 64'd0);
    checkVal("abort_out7", 64'(bus.out7), 64'h7F);
    checkVal("abort_en", 64'(bus.en_out), 64'hFF);
    Rst = 1'b1;
    expQ.push_back('{disp: 32'd0, ovf: 1'b0, blen: 0});
    e = expQ.pop_front();
    verifyDisp(e, 1'b0);
    verifyDisp(e, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Parametrised successor to the fixed two-number, 8-digit seven-segment driver used on the CPU top-level board.
- Drives a DIGITS-wide multiplexed common-anode display from one of NUM_CH DATA_W-bit channels (e.g. V0, V1, cycle count).
- Display mode is runtime-selectable: hex, or decimal via a sequential double-dabble converter.
- Supports leading-zero blanking and an overflow flag. Sits on the board clock beside the CPU.

Parameters:
- DIGITS, 8, number of display digits (2..16).
- DATA_W, 32, width of each input channel (4..64).
- NUM_CH, 2, number of selectable input channels (1..8).
- SCAN_DIV, 100000, Clk cycles each digit is held enabled (≥2).

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- Rst  input  1  synchronous reset, active-low.
- data_in  input  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- ch_sel  input  max(1,clog2(NUM_CH))  channel to capture; values ≥NUM_CH capture 0.
- mode  input  1  0 = hex, 1 = decimal; sampled with update.
- blank_lz  input  1  1 = blank leading zero digits (live, not sampled).
- update  input  1  single-cycle capture strobe.
- busy  output  1  conversion in progress.
- ovf  output  1  captured value does not fit in DIGITS digits.
- out7  output  7  segments a..g, active-low, out7[6]=a … out7[0]=g.
- en_out  output  DIGITS  digit enables, active-low one-hot.

Behaviour:
- Reset (Rst=0 at edge):
  - FSM to IDLE; display register = 0; busy=0; ovf=0; scan index=0; divider=0.
  - out7=7'h7F, en_out=all ones.
  - Reset mid-conversion aborts it; the partial result is discarded.
- FSM states: IDLE, HEX, DEC.
  - IDLE: update=1 captures data_in[ch_sel] and mode.
    - mode=0 → HEX.
    - mode=1 → DEC; shift register loaded; BCD accumulator cleared.
  - HEX (1 cycle):
    - Display register = low DIGITS nibbles of the captured value; missing high nibbles = 0.
    - ovf = any captured bit above 4*DIGITS-1 set.
    - → IDLE.
  - DEC (exactly DATA_W cycles): double-dabble.
    - Each cycle: add 3 to every BCD digit ≥5, then shift left 1 with the next MSB of the value.
    - Accumulator holds ceil(DATA_W*0.30103)+1 digits.
    - After the last shift: display register = low DIGITS BCD digits; ovf = any higher BCD digit nonzero; → IDLE.
- busy:
  - 1 in the cycle after a captured update, through the cycle the result is written.
  - HEX: busy=1 for 1 cycle. DEC: busy=1 for DATA_W cycles.
  - The display register changes on the edge where busy falls.
- update while busy (or in the same cycle busy falls): ignored; no queueing.
- The old display value is held on the outputs throughout a conversion.
- Scan:
  - Divider counts 0..SCAN_DIV-1 continuously from reset release.
  - On wrap, the scan index advances mod DIGITS (DIGITS-1 → 0).
  - en_out = ~(1<<index), registered.
  - out7 = registered decode of display digit[index]; out7 and en_out change on the same edge.
- Decode (active-low, a..g):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- Blanking:
  - With blank_lz=1, every digit above the most significant nonzero digit outputs out7=7'h7F.
  - Digit 0 is never blanked, so the value 0 shows "0".
  - Blanking does not alter en_out.
- ovf holds until the next completed conversion.

Test Plan:
- Reset/scan: assert Rst=0 for 3 cycles with SCAN_DIV=4 → out7=7F, en_out=FF, busy=0. Release → en_out steps FE, FD, …, 7F, FE, changing every 4 cycles.
- Hex: ch 1 = 0x1234ABCD, ch_sel=1, mode=0, pulse update → busy high 1 cycle. Digit 7 shows 1001111 ("1"); digit 0 shows 0111000 ("F" missing? no: D → 1000010); ovf=0.
- Decimal: value 12345678, mode=1 → busy high exactly 32 cycles, then digits 7..0 = 1,2,3,4,5,6,7,8; ovf=0.
- Overflow: 0xFFFFFFFF decimal → displays 94967295; ovf=1. A following decimal conversion of 5 → ovf=0.
- Blanking: value 42 decimal with blank_lz=1 → digits 7..2 = 7F, digit 1 = "4", digit 0 = "2". Value 0 → only digit 0 lit, showing "0".
- Collisions: update during DEC at cycle 10 → ignored; result still 12345678. Rst=0 at cycle 20 of DEC → display=0, busy=0 next cycle.
